// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// instruction classes and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_R_ALU,
    CLS_JR,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_ADDI,
    CLS_XORI,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  // First state after DECODE for each instruction class.
  function automatic state_t class_to_state(input instr_class_t cls);
    case (cls)
      CLS_R_ALU:         return ST_EXEC_R;
      CLS_JR:            return ST_JUMP;
      CLS_LW, CLS_SW:    return ST_MEM_ADDR;
      CLS_BEQ, CLS_BNE:  return ST_BRANCH;
      CLS_J, CLS_JAL:    return ST_JUMP;
      CLS_ADDI, CLS_XORI: return ST_EXEC_I;
      default:           return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: {opcode, funct} -> instruction class
// and the ALU operation the execute state should request.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [2:0]   alu_op
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            cls    = CLS_R_ALU;
            alu_op = ALU_ADD;
          end
          FN_SUB: begin
            cls    = CLS_R_ALU;
            alu_op = ALU_SUB;
          end
          FN_SLT: begin
            cls    = CLS_R_ALU;
            alu_op = ALU_SLT;
          end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cls    = CLS_BNE;
        alu_op = ALU_SUB;
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      OP_ADDI: cls = CLS_ADDI;
      OP_XORI: begin
        cls    = CLS_XORI;
        alu_op = ALU_XOR;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: holds the state register, latches the
// decoded instruction class in DECODE and drives datapath controls from state.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               ir_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               iord,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t       state_q, state_d;
  instr_class_t cls_q, cls_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         illegal_q, illegal_d;

  instr_class_t dec_cls;
  logic [2:0]   dec_alu_op;
  logic         mem_ok;
  ctrl_t        ctrl;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls),
    .alu_op (dec_alu_op)
  );

  assign mem_ok = (USE_MEM_READY == 0) || mem_ready;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ok) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Class is captured here so later states do not depend on IR staying put.
        cls_d    = dec_cls;
        alu_op_d = dec_alu_op;
        state_d  = class_to_state(dec_cls);
        if (dec_cls == CLS_ILLEGAL) illegal_d = 1'b1;
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_WB_I:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (cls_q == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ok) state_d = ST_WB_MEM;
      end
      ST_WB_MEM:   state_d = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ok) state_d = ST_FETCH;
      end
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_TRAP: begin
        state_d   = ST_TRAP;
        illegal_d = 1'b1;
      end
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_ILLEGAL;
      alu_op_q  <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode; FETCH completion and BRANCH pc_we also look at live inputs.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_re = 1'b1;
        ctrl.iord   = 1'b0;
        if (mem_ok) begin
          ctrl.ir_we  = 1'b1;
          ctrl.pc_we  = 1'b1;
          ctrl.pc_src = PC_SRC_PC4;
        end
      end
      ST_EXEC_R: begin
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = alu_op_q;
      end
      ST_WB_R: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = M2R_ALU;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_b = (cls_q == CLS_XORI) ? SRCB_ZEXT : SRCB_SEXT;
        ctrl.alu_op    = alu_op_q;
      end
      ST_WB_I: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_ALU;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_re = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_MEM;
      end
      ST_MEM_WR: begin
        ctrl.mem_we = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.pc_src    = PC_SRC_BRANCH;
        ctrl.pc_we     = (cls_q == CLS_BEQ) ? zero : ~zero;
      end
      ST_JUMP: begin
        case (cls_q)
          CLS_J: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_JUMP;
          end
          CLS_JAL: begin
            ctrl.pc_we      = 1'b1;
            ctrl.pc_src     = PC_SRC_JUMP;
            ctrl.reg_we     = 1'b1;
            ctrl.reg_dst    = REG_DST_RA;
            ctrl.mem_to_reg = M2R_PC4;
          end
          CLS_JR: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_REG;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Reset silences every strobe at once, including a write in flight.
    if (reset) ctrl = '0;
  end

  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign ir_we      = ctrl.ir_we;
  assign mem_re     = ctrl.mem_re;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign reg_we     = ctrl.reg_we;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = illegal_q & ~reset;
  assign state      = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its expected
// per-cycle control pattern, which is popped and compared cycle by cycle.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_re, mem_we, iord, reg_we, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_ctrl #(.USE_MEM_READY(1), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .iord       (iord),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Strobe vector order: {illegal, pc_we, ir_we, mem_re, mem_we, iord, reg_we}
  localparam logic [6:0] S_NONE       = 7'b0000000;
  localparam logic [6:0] S_FETCH_WAIT = 7'b0001000;
  localparam logic [6:0] S_FETCH_GO   = 7'b0111000;
  localparam logic [6:0] S_MEM_RD     = 7'b0001010;
  localparam logic [6:0] S_MEM_WR     = 7'b0000110;
  localparam logic [6:0] S_WB         = 7'b0000001;
  localparam logic [6:0] S_PCW        = 7'b0100000;
  localparam logic [6:0] S_PCW_REG    = 7'b0100001;
  localparam logic [6:0] S_ILLEGAL    = 7'b1000000;

  typedef struct {
    logic        mr;
    logic        z;
    logic [3:0]  st;
    logic [6:0]  strb;
    logic [6:0]  strb_mask;
    logic [10:0] mux;
    logic [10:0] mux_mask;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // en = {pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op} fields to check
  task automatic push(input state_t st, input logic mr, input logic z, input logic [6:0] strb,
                      input logic [6:0] smask, input logic [4:0] en, input logic [1:0] pcs,
                      input logic [1:0] rd, input logic [1:0] m2r, input logic [1:0] sb,
                      input logic [2:0] op);
    exp_t e;
    e.mr        = mr;
    e.z         = z;
    e.st        = st;
    e.strb      = strb;
    e.strb_mask = smask;
    e.mux       = {pcs, rd, m2r, sb, op};
    e.mux_mask  = {{2{en[4]}}, {2{en[3]}}, {2{en[2]}}, {2{en[1]}}, {3{en[0]}}};
    sb_q.push_back(e);
  endtask

  // Expected sequence for one instruction, written from the control table.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fstall, input int mstall, input bit abort);
    logic [2:0] aop;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fstall; i++)
      push(ST_FETCH, 1'b0, z, S_FETCH_WAIT, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    push(ST_FETCH, 1'b1, z, S_FETCH_GO, 7'h7f, 5'b10000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    push(ST_DECODE, 1'b1, z, S_NONE, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b101010)) begin
      aop = (fn == 6'b100000) ? 3'b000 : (fn == 6'b100010) ? 3'b001 : 3'b011;
      push(ST_EXEC_R, 1'b1, z, S_NONE, 7'h7f, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b00, aop);
      push(ST_WB_R, 1'b1, z, S_WB, 7'h7f, 5'b01100, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000);
    end else if (op == 6'b000000 && fn == 6'b001000) begin
      push(ST_JUMP, 1'b1, z, S_PCW, 7'h7f, 5'b10000, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      push(ST_MEM_ADDR, 1'b1, z, S_NONE, 7'h7f, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
      for (int i = 0; i < mstall; i++)
        if (op == 6'b100011)
          push(ST_MEM_RD, 1'b0, z, S_MEM_RD, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        else
          push(ST_MEM_WR, 1'b0, z, S_MEM_WR, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      if (!abort) begin
        if (op == 6'b100011) begin
          push(ST_MEM_RD, 1'b1, z, S_MEM_RD, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
          push(ST_WB_MEM, 1'b1, z, S_WB, 7'h7f, 5'b01100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000);
        end else begin
          push(ST_MEM_WR, 1'b1, z, S_MEM_WR, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        end
      end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      push(ST_BRANCH, 1'b1, z, {1'b0, (op == 6'b000100) ? z : ~z, 5'b00000}, 7'h7f,
           5'b10011, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001);
    end else if (op == 6'b000010) begin
      push(ST_JUMP, 1'b1, z, S_PCW, 7'h7f, 5'b10000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000);
    end else if (op == 6'b000011) begin
      push(ST_JUMP, 1'b1, z, S_PCW_REG, 7'h7f, 5'b11100, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000);
    end else if (op == 6'b001000 || op == 6'b001110) begin
      push(ST_EXEC_I, 1'b1, z, S_NONE, 7'h7f, 5'b00011, 2'b00, 2'b00, 2'b00,
           (op == 6'b001000) ? 2'b01 : 2'b10, (op == 6'b001000) ? 3'b000 : 3'b010);
      push(ST_WB_I, 1'b1, z, S_WB, 7'h7f, 5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    end else begin
      // illegal may rise on the first TRAP cycle or the next; checked from then on
      push(ST_TRAP, 1'b1, z, S_NONE, 7'b0111111, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      for (int i = 0; i < 19; i++)
        push(ST_TRAP, 1'b1, z, S_ILLEGAL, 7'h7f, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    end
  endtask

  // Entered and left at a falling edge; one instruction per call.
  task automatic drain(input string name);
    int   n = 0;
    exp_t e;
    logic [6:0]  obs_strb;
    logic [10:0] obs_mux;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mem_ready = e.mr;
      zero      = e.z;
      #1;
      obs_strb = {illegal, pc_we, ir_we, mem_re, mem_we, iord, reg_we};
      obs_mux  = {pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op};
      check_val($sformatf("%s c%0d state", name, n), 32'(state), 32'(e.st));
      check_val($sformatf("%s c%0d strobes", name, n), 32'(obs_strb & e.strb_mask),
                32'(e.strb & e.strb_mask));
      if (e.mux_mask != '0)
        check_val($sformatf("%s c%0d mux", name, n), 32'(obs_mux & e.mux_mask),
                  32'(e.mux & e.mux_mask));
      n++;
      @(negedge clk);
    end
    $display("instr %-9s cycles=%0d total=%0d bad=%0d", name, n, total, bad);
  endtask

  task automatic check_reset_quiet(input string name);
    check_val({name, " state"}, 32'(state), 32'd0);
    check_val({name, " strobes"}, 32'({illegal, pc_we, ir_we, mem_re, mem_we, iord, reg_we}), 32'd0);
    check_val({name, " mux"}, 32'({pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op}), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_quiet("reset");
    @(negedge clk);
    reset = 1'b0;

    issue(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0); drain("add");
    issue(6'b000000, 6'b100010, 1'b0, 1, 0, 1'b0); drain("sub_fst");
    issue(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0); drain("slt");
    issue(6'b001000, 6'b010101, 1'b0, 0, 0, 1'b0); drain("addi");
    issue(6'b001110, 6'b000000, 1'b0, 0, 0, 1'b0); drain("xori");
    issue(6'b100011, 6'b000000, 1'b0, 0, 2, 1'b0); drain("lw_stall");
    issue(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b0); drain("sw");
    issue(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0); drain("beq_z1");
    issue(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0); drain("beq_z0");
    issue(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0); drain("bne_z1");
    issue(6'b000101, 6'b000000, 1'b0, 0, 0, 1'b0); drain("bne_z0");
    issue(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0); drain("j");
    issue(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0); drain("jal");
    issue(6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0); drain("jr");
    issue(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0); drain("trap");

    reset = 1'b1;
    #1;
    check_reset_quiet("trap_reset");
    @(negedge clk);
    reset = 1'b0;
    issue(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0); drain("add_post");

    // sw stalled in MEM_WR, then reset arrives between clock edges
    issue(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1); drain("sw_abort");
    mem_ready = 1'b0;
    #1;
    check_val("sw_abort held mem_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("sw_abort async mem_we", 32'(mem_we), 32'd0);
    check_reset_quiet("sw_abort_reset");
    @(negedge clk);
    reset = 1'b0;
    issue(6'b000000, 6'b100010, 1'b0, 0, 0, 1'b0); drain("sub_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
